// File: rtl/lp_pkg.sv
// LP20 print-side sequencer shared definitions.
// Character codes, FSM states and character classes.
package lp_pkg;

   localparam logic [7:0] HT  = 8'h09;
   localparam logic [7:0] LF  = 8'h0A;
   localparam logic [7:0] VT  = 8'h0B;
   localparam logic [7:0] FF  = 8'h0C;
   localparam logic [7:0] CR  = 8'h0D;
   localparam logic [7:0] SP  = 8'h20;
   localparam logic [7:0] DEL = 8'h7F;

   localparam int WIDTH_DEF   = 132;
   localparam int TABSTOP_DEF = 8;
   localparam int STBW_DEF    = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      RECOV,
      TABCHK
   } state_t;

   typedef enum logic [1:0] {
      K_RAW,
      K_PRT,
      K_CLR,
      K_TAB
   } kind_t;

   function automatic kind_t classify(input logic [7:0] ch);
      kind_t k;
      k = K_RAW;
      unique case (1'b1)
         (ch == HT):                 k = K_TAB;
         (ch inside {LF, VT, FF, CR}): k = K_CLR;
         (ch >= SP && ch < DEL):     k = K_PRT;
         default:                    k = K_RAW;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/lp_colseq_if.sv
// Buffer, CCTR and printer signals of the LP20 sequencer.
// slave is the sequencer side, master the environment side.
interface lp_colseq_if;

   logic       lpINIT;
   logic       lpONLINE;
   logic       chVALID;
   logic [7:0] chDATA;
   logic       chREADY;
   logic [7:0] regCCTR;
   logic       lpINCCCTR;
   logic       lpCLRCCTR;
   logic       lpDEMAND;
   logic [7:0] lpPIDATA;
   logic       lpSTROBE;
   logic       lpOVFL;

   modport slave (
      input  lpINIT, lpONLINE, chVALID, chDATA,
      input  regCCTR, lpDEMAND,
      output chREADY, lpINCCCTR, lpCLRCCTR,
      output lpPIDATA, lpSTROBE, lpOVFL
   );

   modport master (
      output lpINIT, lpONLINE, chVALID, chDATA,
      output regCCTR, lpDEMAND,
      input  chREADY, lpINCCCTR, lpCLRCCTR,
      input  lpPIDATA, lpSTROBE, lpOVFL
   );

endinterface

// File: rtl/lp_strobe_gen.sv
// Printer strobe timer: counts STBW cycles after start.
// first marks the opening strobe cycle, done the last one.
module lp_strobe_gen #(
   parameter int STBW = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic start,
   output logic first,
   output logic done
);

   localparam int CW = $clog2(STBW + 1);

   logic [CW-1:0] cnt;
   logic          fst;

   // Load the width on start, then count down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         fst <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         fst <= 1'b0;
      end else if (start) begin
         cnt <= CW'(STBW);
         fst <= 1'b1;
      end else begin
         if (cnt != '0) cnt <= cnt - CW'(1);
         fst <= 1'b0;
      end
   end

   assign first = fst;
   assign done  = (cnt == CW'(1));

endmodule

// File: rtl/lp_colseq.sv
// LP20 character sequencer: buffer to printer handshake,
// CCTR pulses, tab expansion and line overflow.
module lp_colseq
   import lp_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TABSTOP = TABSTOP_DEF,
   parameter int STBW    = STBW_DEF
) (
   input logic        clk,
   input logic        rst,
   lp_colseq_if.slave bus
);

   localparam logic [7:0] WLIM  = 8'(WIDTH);
   localparam logic [7:0] TMASK = 8'(TABSTOP - 1);

   state_t     state, nxt;
   kind_t      kind, kind_in;
   logic [7:0] data;
   logic       tab, ovfl;
   logic       accept, over, drop, tab_in, tab_more;
   logic       sg_start, sg_first, sg_done;

   assign kind_in  = classify(bus.chDATA);
   assign tab_in   = (kind_in == K_TAB);
   assign over     = (bus.regCCTR >= WLIM);
   assign tab_more = ((bus.regCCTR & TMASK) != 8'd0) && !over;

   assign accept = (state == IDLE) && !bus.lpINIT &&
                   bus.chVALID && bus.lpDEMAND &&
                   bus.lpONLINE;

   assign drop = accept && over &&
                 (kind_in == K_PRT || tab_in);

   lp_strobe_gen #(.STBW(STBW)) u_stb (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.lpINIT),
      .start (sg_start),
      .first (sg_first),
      .done  (sg_done)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next state; INIT aborts whatever is in flight.
   always_comb begin
      nxt      = state;
      sg_start = 1'b0;
      if (bus.lpINIT) begin
         nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (accept && !drop) nxt = SETUP;
            SETUP: begin
               nxt      = STROBE;
               sg_start = 1'b1;
            end
            STROBE:
               if (sg_done) nxt = RECOV;
            RECOV:
               nxt = tab ? TABCHK : IDLE;
            TABCHK:
               if (!tab_more)        nxt = IDLE;
               else if (bus.lpDEMAND) nxt = SETUP;
            default:
               nxt = IDLE;
         endcase
      end
   end

   // Latch the character on acceptance; HT is sent as spaces.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= 8'h00;
         kind <= K_RAW;
         tab  <= 1'b0;
         ovfl <= 1'b0;
      end else if (bus.lpINIT) begin
         data <= 8'h00;
         kind <= K_RAW;
         tab  <= 1'b0;
         ovfl <= 1'b0;
      end else if (drop) begin
         ovfl <= 1'b1;
      end else if (accept) begin
         data <= tab_in ? SP : bus.chDATA;
         kind <= tab_in ? K_PRT : kind_in;
         tab  <= tab_in;
      end
   end

   assign bus.chREADY   = accept;
   assign bus.lpPIDATA  = data;
   assign bus.lpSTROBE  = (state == STROBE);
   assign bus.lpINCCCTR = (state == STROBE) && sg_first &&
                          (kind == K_PRT);
   assign bus.lpCLRCCTR = (state == STROBE) && sg_first &&
                          (kind == K_CLR);
   assign bus.lpOVFL    = ovfl;

endmodule

// File: tb/tb_lp_colseq.sv
// Bench for lp_colseq: directed cases plus random traffic.
// Scoreboard of expected strobes fed from a column model.
module tb_lp_colseq;

   localparam int W  = 132;
   localparam int TS = 8;
   localparam int SB = 2;

   typedef struct {
      logic [7:0] d;
      bit         inc;
      bit         clr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   lp_colseq_if bus();

   lp_colseq #(
      .WIDTH   (W),
      .TABSTOP (TS),
      .STBW    (SB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   col_m  = 0;
   bit   ovfl_m = 1'b0;
   bit   dem_rand = 1'b0;
   bit   on_rand  = 1'b0;

   logic [7:0] cctr;
   logic       cset = 1'b0;
   logic [7:0] cval = 8'h00;

   assign bus.regCCTR = cctr;

   // Column Count Register as the printer side keeps it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cctr <= 8'h00;
      else if (cset)          cctr <= cval;
      else if (bus.lpCLRCCTR) cctr <= 8'h00;
      else if (bus.lpINCCCTR) cctr <= cctr + 8'd1;
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // What the printer should see for one accepted character.
   function automatic void model(input logic [7:0] ch);
      int n;
      if (ch == 8'h09) begin
         if (col_m >= W) begin
            ovfl_m = 1'b1;
         end else begin
            n = TS - (col_m % TS);
            if (n > W - col_m) n = W - col_m;
            repeat (n) q.push_back('{8'h20, 1'b1, 1'b0});
            col_m += n;
         end
      end else if (ch >= 8'h0A && ch <= 8'h0D) begin
         q.push_back('{ch, 1'b0, 1'b1});
         col_m = 0;
      end else if (ch >= 8'h20 && ch <= 8'h7E) begin
         if (col_m >= W) begin
            ovfl_m = 1'b1;
         end else begin
            q.push_back('{ch, 1'b1, 1'b0});
            col_m++;
         end
      end else begin
         q.push_back('{ch, 1'b0, 1'b0});
      end
   endfunction

   logic       prev_stb = 1'b0;
   logic       prev_rdy = 1'b0;
   int         swidth   = 0;
   bit         aborted  = 1'b0;
   logic [7:0] held     = 8'h00;

   // Monitor: score every strobe rise against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.lpSTROBE && !prev_stb) begin
            if (q.size() == 0) begin
               chk("strobe_unexpected", bus.lpPIDATA, 32'hFFFF);
            end else begin
               e = q.pop_front();
               chk("pidata", bus.lpPIDATA, e.d);
               chk("inc", bus.lpINCCCTR, e.inc);
               chk("clr", bus.lpCLRCCTR, e.clr);
            end
            held    = bus.lpPIDATA;
            swidth  = 0;
            aborted = 1'b0;
         end else if (bus.lpINCCCTR || bus.lpCLRCCTR) begin
            chk("stray_pulse",
                {bus.lpINCCCTR, bus.lpCLRCCTR}, 0);
         end
         if (bus.lpSTROBE) begin
            swidth++;
            if (bus.lpINIT) aborted = 1'b1;
            if (bus.lpPIDATA !== held)
               chk("pidata_stable", bus.lpPIDATA, held);
         end
         if (!bus.lpSTROBE && prev_stb && !aborted)
            chk("strobe_width", swidth, SB);
         if (bus.chREADY && prev_rdy)
            chk("ready_twice", bus.chREADY, 0);
         prev_stb = bus.lpSTROBE;
         prev_rdy = bus.chREADY;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (dem_rand) bus.lpDEMAND = ($urandom_range(3) != 0);
      if (on_rand)  bus.lpONLINE = ($urandom_range(7) != 0);
   endtask

   task automatic send(input logic [7:0] ch);
      bit ok;
      ok = 1'b0;
      tick();
      bus.chDATA  = ch;
      bus.chVALID = 1'b1;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         if (bus.chREADY) ok = 1'b1;
         else             tick();
      end
      if (ok) begin
         model(ch);
         tick();
      end else begin
         chk("accept_timeout", bus.chREADY, 1);
      end
      bus.chVALID = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((q.size() != 0 || bus.lpSTROBE) && k < 400) begin
         tick();
         k++;
      end
      if (k >= 400) chk("drain_timeout", q.size(), 0);
      repeat (6) tick();
   endtask

   task automatic check_state(input string nm);
      logic [7:0] c;
      c = 8'(col_m);
      chk({nm, "_cctr"}, cctr, c);
      chk({nm, "_ovfl"}, bus.lpOVFL, ovfl_m);
   endtask

   task automatic set_col(input int v);
      cval = 8'(v);
      cset = 1'b1;
      tick();
      cset  = 1'b0;
      col_m = v;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit hit, want $finish first");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int r;
      logic [7:0] ch;

      bus.lpINIT   = 1'b0;
      bus.lpONLINE = 1'b1;
      bus.lpDEMAND = 1'b1;
      bus.chVALID  = 1'b0;
      bus.chDATA   = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_ready", bus.chREADY, 0);
      chk("rst_strobe", bus.lpSTROBE, 0);
      chk("rst_inc", bus.lpINCCCTR, 0);
      chk("rst_clr", bus.lpCLRCCTR, 0);
      chk("rst_pidata", bus.lpPIDATA, 0);
      chk("rst_ovfl", bus.lpOVFL, 0);

      // 'A' at column 0: cycle-exact timing.
      tick();
      bus.chDATA  = 8'h41;
      bus.chVALID = 1'b1;
      @(negedge clk);
      chk("A_t0_ready", bus.chREADY, 1);
      model(8'h41);
      tick();
      bus.chVALID = 1'b0;
      @(negedge clk);
      chk("A_t1_pidata", bus.lpPIDATA, 8'h41);
      chk("A_t1_strobe", bus.lpSTROBE, 0);
      tick();
      @(negedge clk);
      chk("A_t2_strobe", bus.lpSTROBE, 1);
      chk("A_t2_inc", bus.lpINCCCTR, 1);
      tick();
      @(negedge clk);
      chk("A_t3_strobe", bus.lpSTROBE, 1);
      chk("A_t3_inc", bus.lpINCCCTR, 0);
      tick();
      @(negedge clk);
      chk("A_t4_strobe", bus.lpSTROBE, 0);
      tick();
      bus.chDATA  = 8'h42;
      bus.chVALID = 1'b1;
      @(negedge clk);
      chk("A_t5_idle_ready", bus.chREADY, 1);
      model(8'h42);
      tick();
      bus.chVALID = 1'b0;
      drain();
      check_state("AB");

      set_col(5);
      send(8'h09);
      drain();
      check_state("ht5");

      set_col(40);
      send(8'h0D);
      drain();
      check_state("cr40");

      set_col(130);
      send(8'h09);
      drain();
      check_state("ht130");

      send(8'h58);
      drain();
      check_state("ovf_X");
      send(8'h09);
      drain();
      check_state("ovf_ht");
      send(8'h0A);
      drain();
      check_state("ovf_lf");

      tick();
      bus.lpINIT = 1'b1;
      tick();
      bus.lpINIT = 1'b0;
      ovfl_m = 1'b0;
      @(negedge clk);
      chk("init_ovfl", bus.lpOVFL, 0);

      // INIT in the first strobe cycle.
      set_col(3);
      tick();
      bus.chDATA  = 8'h51;
      bus.chVALID = 1'b1;
      @(negedge clk);
      chk("abort_ready", bus.chREADY, 1);
      model(8'h51);
      tick();
      bus.chVALID = 1'b0;
      tick();
      bus.lpINIT = 1'b1;
      @(negedge clk);
      chk("abort_t2_strobe", bus.lpSTROBE, 1);
      tick();
      bus.lpINIT = 1'b0;
      @(negedge clk);
      chk("abort_t3_strobe", bus.lpSTROBE, 0);
      drain();
      check_state("abort");
      tick();
      bus.chDATA  = 8'h52;
      bus.chVALID = 1'b1;
      @(negedge clk);
      chk("abort_idle_ready", bus.chREADY, 1);
      model(8'h52);
      tick();
      bus.chVALID = 1'b0;
      drain();
      check_state("after_abort");

      // Offline printer holds off acceptance.
      tick();
      bus.lpONLINE = 1'b0;
      bus.chDATA   = 8'h5A;
      bus.chVALID  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.chREADY) seen = 1'b1;
         tick();
      end
      chk("offline_no_ready", seen, 0);
      bus.lpONLINE = 1'b1;
      @(negedge clk);
      chk("online_ready", bus.chREADY, 1);
      model(8'h5A);
      tick();
      bus.chVALID = 1'b0;
      drain();
      check_state("online");

      // Random traffic with stalling printer.
      dem_rand = 1'b1;
      on_rand  = 1'b1;
      for (int n = 0; n < 160; n++) begin
         r = $urandom_range(99);
         if (r < 55)      ch = 8'($urandom_range(32, 126));
         else if (r < 65) ch = 8'h09;
         else if (r < 75) ch = 8'($urandom_range(10, 13));
         else             ch = 8'($urandom_range(255));
         send(ch);
         if (n % 25 == 24) begin
            drain();
            check_state("rand");
            set_col($urandom_range(140));
         end
      end
      dem_rand = 1'b0;
      on_rand  = 1'b0;
      bus.lpDEMAND = 1'b1;
      bus.lpONLINE = 1'b1;
      drain();
      check_state("final");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lp_colseq.md
# lp_colseq

LP20 print-side character sequencer. It consumes characters from the LP20 data buffer and drives them to the printer interface with a data/strobe/demand handshake. It produces the column-count increment and clear pulses that keep the Column Count Register (CCTR) in step with the print head. It also expands horizontal tabs and flags line overflow.

## Interface
- `WIDTH`, default 132: printable columns per line; this is the overflow limit.
- `TABSTOP`, default 8: tab interval, a power of two.
- `STBW`, default 2: printer strobe width in clk cycles, at least 1.

Ports:
- `clk`  in  1  Clock.
- `rst`  in  1  Reset, asynchronous, active-high.
- `lpINIT`  in  1  Synchronous initialize.
- `lpONLINE`  in  1  Printer online.
- `chVALID`  in  1  Buffer holds a character.
- `chDATA`  in  8  Character from the buffer.
- `chREADY`  out  1  One-cycle pulse when the character is consumed.
- `regCCTR`  in  8  Current CCTR value.
- `lpINCCCTR`  out  1  One-cycle CCTR increment pulse.
- `lpCLRCCTR`  out  1  One-cycle CCTR clear pulse.
- `lpDEMAND`  in  1  Printer ready for a character.
- `lpPIDATA`  out  8  Data to the printer.
- `lpSTROBE`  out  1  Printer data strobe.
- `lpOVFL`  out  1  Sticky line-overflow flag.

## Operation
- Reset values: all outputs 0, state IDLE.
- `lpINIT` has the same effect as reset, but is synchronous. It takes priority over every other input and aborts any transfer in progress.
- States: IDLE, SETUP, STROBE, RECOV, TABCHK.
- IDLE:
  - A character is accepted when `chVALID & lpDEMAND & lpONLINE` are all 1. On acceptance, pulse `chREADY`, latch `chDATA` and decode it.
  - If `lpONLINE` is 0, no character is accepted. A transfer already started always completes.
- Character classes:
  - **Printable (0x20–0x7E):**
    - If `regCCTR >= WIDTH`: drop the character, set `lpOVFL`, return to IDLE.
    - Otherwise go to SETUP and pulse `lpINCCCTR` on the first STROBE cycle.
  - **Line/form control (0x0A LF, 0x0B VT, 0x0C FF, 0x0D CR):** go to SETUP and pulse `lpCLRCCTR` on the first STROBE cycle.
  - **HT (0x09):**
    - Not sent to the printer. It is replaced by a space (0x20) and sent as printable.
    - After each space, go through TABCHK.
    - In TABCHK, send another space if `regCCTR mod TABSTOP != 0` and `regCCTR < WIDTH`. Otherwise return to IDLE.
    - HT accepted at column 0 sends 8 spaces. HT at column 5 sends 3 spaces.
    - HT when `regCCTR >= WIDTH` sends nothing and sets `lpOVFL`.
  - **Other control codes (0x00–0x1F not listed above, 0x7F, 0x80–0xFF):** sent unchanged, with no column pulse.
- SETUP: drive `lpPIDATA` for one cycle with `lpSTROBE` low.
- STROBE: hold `lpSTROBE` high for STBW cycles with `lpPIDATA` stable.
- RECOV: one cycle with strobe low. Then go to IDLE, or to TABCHK when expanding a tab.
- TABCHK:
  - Waits for `lpDEMAND` before sending the next space.
  - Evaluates the updated `regCCTR` value; the CCTR has registered the increment by this point.
- `lpOVFL` stays set until `lpINIT` or reset. It does not block CR, LF, VT or FF.
- `lpCLRCCTR` and `lpINCCCTR` are never asserted in the same cycle.

## Timing
- Acceptance to strobe rise: 2 cycles (accept cycle, then SETUP).
- Each character occupies 1 + STBW + 1 cycles after acceptance.
- Back-to-back throughput is at most one character per STBW + 3 cycles.
- `lpINCCCTR` and `lpCLRCCTR` coincide with the first strobe cycle. Their effect on `regCCTR` is visible from the second STROBE cycle onward.
- `lpPIDATA` changes only in SETUP. It holds its value in IDLE.
- The printer must drop `lpDEMAND` within 1 cycle of strobe fall. `lpDEMAND` is sampled again in IDLE or TABCHK.
- `lpINIT` during STROBE forces `lpSTROBE` low on the next edge. No further INC/CLR pulses are issued for that character.
- `chVALID` held continuously: exactly one `chREADY` per character, never two in consecutive cycles.

## Structure
- Shared package `lp_pkg`:
  - Character constants: HT, LF, VT, FF, CR, SP, DEL.
  - State enum.
  - Defaults for WIDTH and TABSTOP.
- Sub-module `lp_strobe_gen`: an STBW-cycle strobe timer with a start input and a done output, used by STROBE.

## Test plan
- 'A' with `regCCTR` = 0, DEMAND = 1, STBW = 2 → `chREADY` at t0, `lpPIDATA` = 0x41 at t1, `lpSTROBE` high at t2–t3 with `lpINCCCTR` at t2, back in IDLE at t5.
- HT with `regCCTR` = 5 (CCTR model connected) → 3 strobes of 0x20, three INC pulses, final CCTR = 8.
- CR with CCTR = 40 → 0x0D strobed, one `lpCLRCCTR`, CCTR = 0, no INC.
- CCTR = 132, 'X' → no strobe, `lpOVFL` = 1, `chREADY` pulsed. Then LF → strobed, CLR pulsed, `lpOVFL` still 1. Then `lpINIT` → `lpOVFL` = 0.
- `lpINIT` asserted in the first STROBE cycle → `lpSTROBE` low next cycle, state IDLE, no further pulses.
- `lpONLINE` = 0 with `chVALID` = 1 → no `chREADY`. Raise `lpONLINE` → accepted on the next cycle.
